// File: rtl/i2c_master.sv
// Single-byte I2C write master: START, address+R/W, ACK, data, ACK, STOP.
// Define I2C_ACK_CHECK_EN to act on NACKs (sets ack_err, aborts after address NACK).
module i2c_master #(
  parameter int HALF_TICKS = 5
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clk_1MHz,
  input  logic [6:0] addr,
  input  logic       rd_wr,
  input  logic [7:0] data,
  input  logic       comm_go,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda,
  output logic       busy,
  output logic       ack_err
);

  localparam int CW = $clog2(3 * HALF_TICKS) + 1;
  localparam logic [CW-1:0] T1 = CW'(HALF_TICKS - 1);
  localparam logic [CW-1:0] T2 = CW'(2 * HALF_TICKS - 1);
  localparam logic [CW-1:0] T3 = CW'(3 * HALF_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ACK1, DATA, ACK2, STOP
  } state_t;

  state_t        state;
  logic          clk1_q;
  logic          go_q;
  logic          tick;
  logic          go_rise;
  logic          nack;
  logic          err_q;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    abyte;
  logic [7:0]    dbyte;

  assign tick    = clk_1MHz & ~clk1_q;
  assign go_rise = comm_go & ~go_q;

`ifdef I2C_ACK_CHECK_EN
  assign nack    = sda_in;
  assign ack_err = err_q;
`else
  logic unused_ok;
  assign nack      = 1'b0;
  assign ack_err   = 1'b0;
  assign unused_ok = sda_in ^ err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state  <= IDLE;
      scl    <= 1'b1;
      sda    <= 1'b1;
      busy   <= 1'b0;
      err_q  <= 1'b0;
      cnt    <= '0;
      bitn   <= '0;
      abyte  <= '0;
      dbyte  <= '0;
      clk1_q <= 1'b1;
      go_q   <= 1'b0;
    end else begin
      clk1_q <= clk_1MHz;
      go_q   <= comm_go;
      unique case (state)
        IDLE: begin
          if (go_rise) begin
            abyte <= {addr, rd_wr};
            dbyte <= data;
            busy  <= 1'b1;
            err_q <= 1'b0;
            sda   <= 1'b0;
            scl   <= 1'b1;
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (cnt == T1) begin
              cnt   <= '0;
              scl   <= 1'b0;
              bitn  <= 3'd7;
              sda   <= abyte[7];
              state <= ADDR;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ADDR, DATA: begin
          if (tick) begin
            if (cnt == T2) begin
              cnt <= '0;
              scl <= 1'b0;
              // explicit zero test so the counter never wraps into a 9th bit
              if (bitn == 3'd0) begin
                sda   <= 1'b1;
                state <= (state == ADDR) ? ACK1 : ACK2;
              end else begin
                bitn <= bitn - 3'd1;
                sda  <= (state == ADDR) ? abyte[bitn - 3'd1]
                                        : dbyte[bitn - 3'd1];
              end
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt == T1) scl <= 1'b1;
            end
          end
        end
        ACK1, ACK2: begin
          if (tick) begin
            if (cnt == T2) begin
              cnt <= '0;
              scl <= 1'b0;
              if (nack) err_q <= 1'b1;
              if (state == ACK1 && !nack) begin
                state <= DATA;
                bitn  <= 3'd7;
                sda   <= dbyte[7];
              end else begin
                state <= STOP;
                sda   <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt == T1) scl <= 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (cnt == T3) begin
              cnt   <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt == T1) scl <= 1'b1;
              if (cnt == T2) sda <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: tick-level bus model, bus decoder, directed and random runs.
// Honours I2C_ACK_CHECK_EN the same way as the design.
module tb_i2c_master;

  localparam int H = 5;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       clk_1MHz = 1'b0;
  logic [6:0] addr = 7'h27;
  logic       rd_wr = 1'b0;
  logic [7:0] data = 8'hA5;
  logic       comm_go = 1'b0;
  logic       sda_in = 1'b0;
  logic       scl, sda, busy, ack_err;

  int checks = 0;
  int errors = 0;

  i2c_master #(.HALF_TICKS(H)) dut (
    .clk(clk), .reset_p(reset_p), .clk_1MHz(clk_1MHz),
    .addr(addr), .rd_wr(rd_wr), .data(data),
    .comm_go(comm_go), .sda_in(sda_in),
    .scl(scl), .sda(sda), .busy(busy), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int half_div = 50;
  int dcnt = 0;
  always @(negedge clk) begin
    dcnt++;
    if (dcnt >= half_div) begin
      dcnt = 0;
      clk_1MHz = ~clk_1MHz;
    end
  end

  logic rand_sda = 1'b0;
  always @(negedge clk) if (rand_sda) sda_in = 1'($urandom);

  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference: tick count since START entry maps straight onto bus segments.
  logic       m_act, m_nack, m_err, m_c1q, m_gq, m_tick;
  int         n;
  logic [7:0] m_a, m_d;
  logic       ack1_nack, ack2_nack;

`ifdef I2C_ACK_CHECK_EN
  assign ack1_nack = (n == 19 * H - 1) && sda_in;
  assign ack2_nack = (n == 37 * H - 1) && sda_in;
`else
  assign ack1_nack = 1'b0;
  assign ack2_nack = 1'b0;
`endif

  always @(posedge clk) begin
    if (reset_p) begin
      m_act <= 0; n <= 0; m_err <= 0; m_nack <= 0;
      m_c1q <= 1; m_gq <= 0; m_tick <= 0;
    end else begin
      m_tick <= clk_1MHz & ~m_c1q;
      m_c1q  <= clk_1MHz;
      m_gq   <= comm_go;
      if (!m_act) begin
        if (comm_go && !m_gq) begin
          m_act <= 1; n <= 0; m_err <= 0; m_nack <= 0;
          m_a <= {addr, rd_wr}; m_d <= data;
        end
      end else if (clk_1MHz && !m_c1q) begin
        if (ack1_nack || ack2_nack) m_err <= 1;
        m_nack <= m_nack | ack1_nack;
        n <= n + 1;
        if (n + 1 == ((m_nack | ack1_nack) ? 22 * H : 40 * H)) m_act <= 0;
      end
    end
  end

  function automatic logic [1:0] exp_bus(int t, logic nk,
                                         logic [7:0] a, logic [7:0] d);
    logic [17:0] seq;
    int s, np, p;
    seq = {a, 1'b1, d, 1'b1};
    s = t / H;
    np = nk ? 9 : 18;
    if (s == 0) return 2'b10;
    if (s <= 2 * np) begin
      p = (s - 1) / 2;
      return {((s - 1) % 2) == 1, seq[17 - p]};
    end
    s = s - 1 - 2 * np;
    if (s == 0) return 2'b00;
    if (s == 1) return 2'b10;
    return 2'b11;
  endfunction

  // Per-cycle compare, phase timing, edge legality and bit decoding.
  logic        chk_en = 0;
  logic        scl_q = 1, sda_q = 1, busy_q = 0, ph_ok = 0, abort = 0;
  logic [1:0]  eb;
  logic [31:0] cap = 0, expv;
  int          capn = 0, tcnt = 0, bticks = 0, rise_cyc = 0;
  int          last_capn = 0, last_ticks = 0, last_cyc = 0, done_cnt = 0;
  logic [31:0] last_cap = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      eb = m_act ? exp_bus(n, m_nack, m_a, m_d) : 2'b11;
      chk("scl", scl, eb[1]);
      chk("sda", sda, eb[0]);
      chk("busy", busy, m_act);
      chk("ack_err", ack_err, m_err);
      if (m_tick) tcnt++;
      if (busy_q && m_tick) bticks++;
      if (busy && !busy_q) begin
        tcnt = 0; ph_ok = 1; cap = 0; capn = 0;
        abort = 0; bticks = 0; rise_cyc = cyc;
      end
      if (reset_p) abort = 1;
      if (busy && scl !== scl_q) begin
        if (ph_ok) chk("phase_ticks", tcnt, H);
        tcnt = 0;
      end
      if (busy && scl && !scl_q) begin
        cap = {cap[30:0], sda};
        capn++;
      end
      if (scl && scl_q && sda !== sda_q) begin
        if (!sda) chk("start_edge", {busy_q, busy}, 2'b01);
        else if (!abort) chk("stop_edge", busy, 1);
      end
      if (!busy && busy_q && !abort) begin
        expv = m_nack ? {22'b0, m_a, 2'b10}
                      : {13'b0, m_a, 1'b1, m_d, 2'b10};
        chk("bits", cap, expv);
        chk("nbits", capn, m_nack ? 10 : 19);
        last_cap = cap; last_capn = capn;
        last_ticks = bticks; last_cyc = cyc - rise_cyc;
        done_cnt++;
      end
      scl_q = scl; sda_q = sda; busy_q = busy;
    end
  end

  task automatic step(int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic pulse_go();
    comm_go = 1;
    step(2);
    comm_go = 0;
  endtask

  task automatic pulse_reset();
    reset_p = 1;
    step(1);
    reset_p = 0;
  endtask

  task automatic wait_idle(int bound);
    int k;
    k = 0;
    while (busy && k < bound) begin
      step(1);
      k++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL timeout: busy still 1 after %0d cycles", bound);
    end
    step(4);
  endtask

  task automatic wait_ticks(int k);
    step(k * 2 * half_div);
  endtask

  task automatic check_full(string nm);
    chk({nm, "_bits"}, last_cap, {13'b0, 19'b0100111_0_1_10100101_1_0});
    chk({nm, "_nbits"}, last_capn, 19);
    chk({nm, "_dur"}, (last_ticks >= 199 && last_ticks <= 201), 1);
    chk({nm, "_ackerr"}, ack_err, 0);
  endtask

  int dc, act, k;

  initial begin
    step(3);
    chk_en = 1;
    step(1);
    reset_p = 0;
    step(2);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ackerr", ack_err, 0);

    // Real 100 MHz / 1 MHz timing for the first transfer.
    dc = done_cnt;
    pulse_go();
    chk("t1_accept", busy, 1);
    wait_idle(25000);
    chk("t1_done", done_cnt, dc + 1);
    check_full("t1");
    chk("t1_cycles", (last_cyc >= 19900 && last_cyc <= 20100), 1);

    // Faster tick clock from here on to keep the run short.
    half_div = 3;
    step(20);
    dc = done_cnt;
    pulse_go();
    wait_ticks(50);
    addr = 7'h11; data = 8'h3C; rd_wr = 1;
    pulse_go();
    wait_idle(5000);
    chk("t2_done", done_cnt, dc + 1);
    check_full("t2");
    addr = 7'h27; data = 8'hA5; rd_wr = 0;

    pulse_go();
    wait_ticks(100);
    pulse_reset();
    chk("mid_rst_scl", scl, 1);
    chk("mid_rst_sda", sda, 1);
    chk("mid_rst_busy", busy, 0);
    step(10);
    dc = done_cnt;
    pulse_go();
    wait_idle(5000);
    chk("t3_done", done_cnt, dc + 1);
    check_full("t3");

`ifdef I2C_ACK_CHECK_EN
    sda_in = 1;
    dc = done_cnt;
    pulse_go();
    wait_idle(5000);
    chk("nack_done", done_cnt, dc + 1);
    chk("nack_bits", last_cap, {22'b0, 10'b0100111_0_1_0});
    chk("nack_dur", (last_ticks >= 21 * H && last_ticks <= 22 * H + 1), 1);
    chk("nack_err", ack_err, 1);
    sda_in = 0;
    step(10);
`endif

    rand_sda = 1;
    for (int i = 0; i < 12; i++) begin
      addr = 7'($urandom);
      rd_wr = 1'($urandom);
      data = 8'($urandom);
      pulse_go();
      k = $urandom_range(0, 160);
      wait_ticks(k);
      act = $urandom_range(0, 3);
      if (act == 0) begin
        addr = 7'($urandom);
        data = 8'($urandom);
        pulse_go();
      end else if (act == 1) begin
        pulse_reset();
      end
      wait_idle(8000);
      step($urandom_range(1, 30));
    end
    rand_sda = 0;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter HALF_TICKS, default 5, number of 1 MHz ticks per SCL half period (5 gives 100 kHz SCL).
REQ-002 SHALL have port clk, input, 1, system clock (100 MHz).
REQ-003 SHALL have port reset_p, input, 1, synchronous active-high reset.
REQ-004 SHALL have port clk_1MHz, input, 1, divided clock from the clock divider, sampled in the clk domain.
REQ-005 SHALL have port addr, input, 7, 7-bit slave address.
REQ-006 SHALL have port rd_wr, input, 1, R/W bit appended to the address (0 = write).
REQ-007 SHALL have port data, input, 8, payload byte.
REQ-008 SHALL have port comm_go, input, 1, transfer request (rising-edge sensitive).
REQ-009 SHALL have port sda_in, input, 1, sampled SDA line for ACK detection.
REQ-010 SHALL have port scl, output, 1, I2C clock line (1 = released).
REQ-011 SHALL have port sda, output, 1, I2C data line (1 = released).
REQ-012 SHALL have port busy, output, 1, high from accepted request until return to IDLE.
REQ-013 SHALL have port ack_err, output, 1, NACK seen on the last transfer.

Function
REQ-014 SHALL use only clk; tick = one-clk pulse on each 0->1 transition of clk_1MHz detected by a register whose reset value is 1, so there is no spurious tick after reset.
REQ-015 SHALL detect comm_go rising edges with a register whose reset value is 0; an edge while busy=1 SHALL be ignored.
REQ-016 SHALL have the states IDLE, START, ADDR, ACK1, DATA, ACK2, STOP; all timing advances only on ticks.
REQ-017 IDLE: scl=1, sda=1, busy=0; an accepted edge latches {addr,rd_wr} and data, sets busy=1, clears ack_err, and enters START.
REQ-018 START: sda=0 on entry, scl=1 for HALF_TICKS ticks, then scl=0 and enter ADDR.
REQ-019 Each bit period SHALL be 2*HALF_TICKS ticks: scl=0 for the first HALF_TICKS ticks and scl=1 for the remainder; sda is updated only at period start, while scl=0.
REQ-020 ADDR SHALL send {addr,rd_wr} MSB first (8 periods); DATA SHALL send data MSB first (8 periods).
REQ-021 ACK1 and ACK2 SHALL last one bit period with sda=1; sda_in is sampled on the final tick of the period, while scl=1.
REQ-022 STOP: sda=0 and scl=0 for HALF_TICKS ticks; then scl=1 for HALF_TICKS ticks; then sda=1 for HALF_TICKS ticks; then IDLE with busy=0.
REQ-023 The total transfer without error SHALL be 40*HALF_TICKS ticks from START entry to IDLE (200 us at default).
REQ-024 The latched bytes SHALL stay stable for the whole transfer; input changes while busy=1 have no effect.
REQ-025 The bit counter SHALL count 7 down to 0, and reloading it SHALL not wrap into a ninth data bit.

Reset
REQ-026 reset_p=1 at a rising clk edge, including mid-transfer, SHALL force the state to IDLE, scl=1, sda=1, busy=0, ack_err=0, and clear all counters by the next clk edge.
REQ-027 reset_p SHALL take priority over comm_go and tick in the same cycle.

Configuration
REQ-028 With I2C_ACK_CHECK_EN defined, sda_in=1 sampled in ACK1 or ACK2 SHALL set ack_err=1; NACK in ACK1 SHALL skip DATA/ACK2 and go directly to STOP. ack_err is held until the next accepted request.
REQ-029 Without I2C_ACK_CHECK_EN, sda_in SHALL be ignored, ack_err SHALL be constant 0, and every transfer SHALL run the full sequence.

Verification
REQ-030 Bench: clk 100 MHz, clk_1MHz toggling every 50 clk; addr=7'h27, rd_wr=0, data=8'hA5, comm_go pulse, sda_in=0 -> SDA bits 0100111_0, ack, 10100101, ack; STOP; busy high for 200 us +/- 1 tick; ack_err=0.
REQ-031 Second comm_go edge 50 us into the transfer -> ignored, with a single transfer of 200 us and the same bit pattern.
REQ-032 With I2C_ACK_CHECK_EN and sda_in=1 during ACK1 -> no DATA bits, STOP follows immediately, ack_err=1, and busy drops after 22*HALF_TICKS ticks (110 us).
REQ-033 reset_p pulsed one clk at 100 us into the transfer -> scl=1, sda=1, busy=0 on the next clk; a new comm_go afterwards completes normally.
REQ-034 Checker on all runs: sda changes only while scl=0, except the START falling edge and the STOP rising edge; the scl high and low phases are each 5 ticks.
